level_progress_ctrl: RTL

Parametrised game-progression controller: tracks level and remaining lives, sequences frog resets, and detects game-over. Restart requires a held four-switch combo. Includes a sequential binary-to-BCD converter that drives the 7-segment digit decoders. Sits between frog_display (frog_at_top, frog_hit) and the segment_display instances.

---
 rtl/level_progress_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/level_progress_ctrl.sv
// level_progress_ctrl
//   Game-progression controller. Tracks the current level and remaining
//   lives, issues frog-reset and level-up pulses, detects game over, and
//   runs a one-bit-per-cycle binary-to-BCD conversion of the level for the
//   7-segment digit decoders.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sw[3:0]      debounced switches; all four held high = restart combo
//   frog_at_top  frog reached the top row (level, rising edge used)
//   frog_hit     frog collided (level, rising edge used)
//   level        current level
//   lives        remaining lives
//   reset_frog   one-cycle pulse: return frog to start
//   level_up     one-cycle pulse on level advance
//   game_over    high while in the OVER state
//   bcd          BCD of level, digit 0 in [3:0]
//   bcd_valid    bcd matches the current level
module level_progress_ctrl #(
    parameter int LEVEL_W      = 7,
    parameter int START_LEVEL  = 1,
    parameter int MAX_LEVEL    = 15,
    parameter int WRAP         = 0,
    parameter int LIVES_W      = 2,
    parameter int LIVES_INIT   = 3,
    parameter int NUM_DIGITS   = 2,
    parameter int RESTART_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              sw,
    input  logic                    frog_at_top,
    input  logic                    frog_hit,
    output logic [LEVEL_W-1:0]      level,
    output logic [LIVES_W-1:0]      lives,
    output logic                    reset_frog,
    output logic                    level_up,
    output logic                    game_over,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    bcd_valid
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int HOLD_W = $clog2(RESTART_HOLD + 1);
    localparam int CNT_W  = $clog2(LEVEL_W + 1);

    localparam logic [LEVEL_W-1:0] LVL_START  = LEVEL_W'(START_LEVEL);
    localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0] LIVES_RST  = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_TGT   = HOLD_W'(RESTART_HOLD);
    localparam logic [CNT_W-1:0]   CONV_STEPS = CNT_W'(LEVEL_W);

    typedef enum logic {ST_PLAY, ST_OVER} state_t;

    state_t               state, state_nx;
    logic [LEVEL_W-1:0]   level_nx;
    logic [LIVES_W-1:0]   lives_nx;
    logic                 reset_frog_nx, level_up_nx;

    logic                 top_hist, hit_hist;
    logic                 top_rise, hit_rise;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 combo, restart;
    logic                 level_chg;

    logic                 conv_pend;
    logic [CNT_W-1:0]     conv_cnt;
    logic [LEVEL_W-1:0]   bin_sh;
    logic [BCD_W-1:0]     acc, acc_adj, acc_step;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r[4*d +: 4] >= 4'd5)
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    // History resets high so an input already asserted at reset release
    // is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_hist <= 1'b1;
            hit_hist <= 1'b1;
        end else begin
            top_hist <= frog_at_top;
            hit_hist <= frog_hit;
        end
    end

    assign top_rise = frog_at_top & ~top_hist;
    assign hit_rise = frog_hit & ~hit_hist;

    // Restart fires only on the cycle the counter reaches its target; the
    // counter then parks there until some switch drops.
    assign combo   = &sw;
    assign restart = combo && (hold_cnt == HOLD_TGT - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (!combo)
            hold_cnt <= '0;
        else if (hold_cnt != HOLD_TGT)
            hold_cnt <= hold_cnt + 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_PLAY;
            level      <= LVL_START;
            lives      <= LIVES_RST;
            reset_frog <= 1'b0;
            level_up   <= 1'b0;
        end else begin
            state      <= state_nx;
            level      <= level_nx;
            lives      <= lives_nx;
            reset_frog <= reset_frog_nx;
            level_up   <= level_up_nx;
        end
    end

    // Next state: restart > frog_hit > frog_at_top; losers are dropped.
    always_comb begin
        state_nx      = state;
        level_nx      = level;
        lives_nx      = lives;
        reset_frog_nx = 1'b0;
        level_up_nx   = 1'b0;
        if (restart) begin
            state_nx      = ST_PLAY;
            level_nx      = LVL_START;
            lives_nx      = LIVES_RST;
            reset_frog_nx = 1'b1;
        end else if (state == ST_PLAY) begin
            if (hit_rise) begin
                reset_frog_nx = 1'b1;
                if (lives != '0)
                    lives_nx = lives - 1'b1;
                if (lives <= LIVES_ONE)
                    state_nx = ST_OVER;
            end else if (top_rise) begin
                reset_frog_nx = 1'b1;
                if (level < LVL_MAX) begin
                    level_nx    = level + 1'b1;
                    level_up_nx = 1'b1;
                end else if (WRAP != 0) begin
                    level_nx    = LVL_START;
                    level_up_nx = 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        game_over = (state == ST_OVER);
    end

    assign level_chg = (level_nx != level);

    // Conversion control: a level change arms conv_pend, which reloads the
    // converter on the next cycle (aborting any conversion in flight).
    assign acc_adj  = dabble_adj(acc);
    assign acc_step = {acc_adj[BCD_W-2:0], bin_sh[LEVEL_W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_pend <= 1'b1;
            conv_cnt  <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            conv_pend <= level_chg;
            if (level_chg)
                bcd_valid <= 1'b0;
            if (conv_pend) begin
                conv_cnt <= CONV_STEPS;
            end else if (conv_cnt != '0) begin
                conv_cnt <= conv_cnt - 1'b1;
                if (conv_cnt == CNT_W'(1) && !level_chg) begin
                    bcd       <= acc_step;
                    bcd_valid <= 1'b1;
                end
            end
        end
    end

    // Shift/accumulate datapath, no reset needed: always loaded before use.
    always_ff @(posedge clk) begin
        if (conv_pend) begin
            bin_sh <= level;
            acc    <= '0;
        end else if (conv_cnt != '0) begin
            bin_sh <= bin_sh << 1;
            acc    <= acc_step;
        end
    end

endmodule
